// File: rtl/ppfifo_pattern_source_pkg.sv
// ppfifo_pattern_source_pkg: shared FSM states, buffer-select codes and pattern step
package ppfifo_pattern_source_pkg;
    typedef enum logic [2:0] {IDLE, ACQUIRE, WRITE, RELEASE, FINISH} state_t;
    localparam logic [1:0] PPFIFO_SEL_NONE = 2'b00;
    localparam logic [1:0] PPFIFO_SEL_0 = 2'b01;
    localparam logic [1:0] PPFIFO_SEL_1 = 2'b10;
    // Full 32-bit compare: seeds above the wrap point keep counting up
    function automatic logic [31:0] next_pattern(input logic [31:0] p, input int w);
        return (p == (32'd1 << w) - 32'd1) ? '0 : p + 32'd1;
    endfunction
endpackage

// File: rtl/ppfifo_pattern_source_if.sv
// ppfifo_pattern_source_if: write side of a ping-pong FIFO
interface ppfifo_pattern_source_if;
    logic [1:0] write_ready;
    logic [1:0] write_activate;
    logic [23:0] write_size;
    logic write_strobe;
    logic [31:0] write_data;
    modport master(input write_ready, write_size, output write_activate, write_strobe, write_data);
    modport slave(output write_ready, write_size, input write_activate, write_strobe, write_data);
endinterface

// File: rtl/ppfifo_write_arbiter.sv
// ppfifo_write_arbiter: claims a ready ping-pong buffer and counts words written into it
module ppfifo_write_arbiter
    import ppfifo_pattern_source_pkg::*;
(
    input logic clk,
    input logic rst,
    input logic acquire,
    input logic hold,
    input logic strobe,
    input logic [1:0] ready,
    output logic grant,
    output logic [1:0] activate,
    output logic [23:0] buf_count
);
    assign grant = acquire && activate == PPFIFO_SEL_NONE && ready != 2'b00;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            activate <= PPFIFO_SEL_NONE;
            buf_count <= '0;
        end else begin
            activate <= !hold ? PPFIFO_SEL_NONE : grant ? (ready[0] ? PPFIFO_SEL_0 : PPFIFO_SEL_1) : activate;
            buf_count <= grant ? '0 : buf_count + 24'(strobe);
        end
    end
endmodule

// File: rtl/ppfifo_pattern_source.sv
// ppfifo_pattern_source: streams an incrementing pattern into a ping-pong FIFO per start request
module ppfifo_pattern_source
    import ppfifo_pattern_source_pkg::*;
#(
    parameter int WRAP_WIDTH = 8,
    parameter int GAP_CYCLES = 0
) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic [31:0] start_value,
    input logic [23:0] word_count,
    input logic inject_error,
    input logic abort,
    output logic busy,
    output logic done,
    output logic [23:0] words_sent,
    ppfifo_pattern_source_if.master wr
);
    state_t state, state_n;
    logic start_q, launch, grant, strobe, err;
    logic [31:0] pattern;
    logic [23:0] remaining, buf_count;
    logic [15:0] gap;

    assign launch = start && !start_q;
    assign busy = state inside {ACQUIRE, WRITE, RELEASE};
    assign done = state == FINISH;
    assign strobe = state == WRITE && wr.write_activate != PPFIFO_SEL_NONE && buf_count < wr.write_size
                    && remaining != 0 && gap == 0 && !abort;
    assign wr.write_strobe = strobe;
    assign wr.write_data = !strobe ? '0 : (err && words_sent == 24'd1) ? ~pattern : pattern;

    ppfifo_write_arbiter u_arb (
        .clk(clk),
        .rst(rst),
        .acquire(state == ACQUIRE),
        .hold(state_n == WRITE),
        .strobe(strobe),
        .ready(wr.write_ready),
        .grant(grant),
        .activate(wr.write_activate),
        .buf_count(buf_count)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = launch ? (word_count == 0 ? FINISH : ACQUIRE) : IDLE;
            ACQUIRE: state_n = grant ? WRITE : ACQUIRE;
            WRITE: state_n = (buf_count >= wr.write_size || remaining == 0) ? RELEASE : WRITE;
            RELEASE: state_n = remaining != 0 ? ACQUIRE : FINISH;
            default: state_n = IDLE;
        endcase
        if (abort && busy) state_n = FINISH;
    end

    // start_q resets high so a start held through reset is not seen as an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            start_q <= 1'b1;
            pattern <= '0;
            remaining <= '0;
            words_sent <= '0;
            err <= 1'b0;
            gap <= '0;
        end else begin
            state <= state_n;
            start_q <= start;
            if (state == IDLE && launch) begin
                pattern <= start_value;
                remaining <= word_count;
                err <= inject_error;
                words_sent <= '0;
                gap <= '0;
            end else begin
                if (strobe) begin
                    pattern <= next_pattern(pattern, WRAP_WIDTH);
                    remaining <= remaining - 24'd1;
                    words_sent <= words_sent + 24'd1;
                end
                gap <= strobe ? 16'(GAP_CYCLES) : gap - 16'(gap != 0);
            end
        end
    end
endmodule

// File: tb/tb_ppfifo_pattern_source.sv
// tb_ppfifo_pattern_source: scenario tasks against a ping-pong FIFO model and a pattern reference
module tb_ppfifo_pattern_source;
    logic clk = 0, rst = 0;
    always #5 clk = ~clk;
    logic start = 0, g_start = 0, inject_error = 0, abort = 0;
    logic [31:0] start_value = 0;
    logic [23:0] word_count = 0;
    logic busy, done, g_busy, g_done;
    logic [23:0] words_sent, g_ws;
    logic [1:0] mask = 2'b11;
    logic [2:0] drain0 = 0, drain1 = 0;
    int cyc = 0, vectors = 0, miscompares = 0;

    ppfifo_pattern_source_if d_if();
    ppfifo_pattern_source_if g_if();
    assign d_if.write_size = 24'd256;
    assign g_if.write_size = 24'd256;
    assign d_if.write_ready = mask & ~d_if.write_activate & {drain1 == 0, drain0 == 0};
    assign g_if.write_ready = ~g_if.write_activate;

    ppfifo_pattern_source u_dut (.clk(clk), .rst(rst), .start(start), .start_value(start_value),
        .word_count(word_count), .inject_error(inject_error), .abort(abort), .busy(busy), .done(done),
        .words_sent(words_sent), .wr(d_if));
    ppfifo_pattern_source #(.WRAP_WIDTH(8), .GAP_CYCLES(3)) u_gap (.clk(clk), .rst(rst), .start(g_start),
        .start_value(start_value), .word_count(word_count), .inject_error(1'b0), .abort(1'b0), .busy(g_busy),
        .done(g_done), .words_sent(g_ws), .wr(g_if));

    // FIFO model: a released buffer drains for a few cycles before it is ready again
    always @(posedge clk) begin
        cyc <= cyc + 1;
        drain0 <= d_if.write_activate[0] ? 3'd4 : (drain0 != 0 ? drain0 - 3'd1 : 3'd0);
        drain1 <= d_if.write_activate[1] ? 3'd4 : (drain1 != 0 ? drain1 - 3'd1 : 3'd0);
    end

    logic [31:0] got_q[$];
    int fills_q[$];
    logic [1:0] bufs_q[$];
    int cur_fill = 0, done_cnt = 0, rule_viol = 0;
    logic [1:0] last_act = 0;
    always @(negedge clk) begin
        if (d_if.write_strobe) got_q.push_back(d_if.write_data);
        if (last_act != 0 && d_if.write_activate == 0) begin
            fills_q.push_back(cur_fill);
            bufs_q.push_back(last_act);
        end
        cur_fill <= (last_act != 0 && d_if.write_activate == 0) ? 0 : cur_fill + int'(d_if.write_strobe);
        rule_viol <= rule_viol + int'(d_if.write_strobe && (d_if.write_activate == 0 || cur_fill >= 256));
        done_cnt <= done_cnt + int'(done);
        last_act <= d_if.write_activate;
    end

    // Reference: values below 256 wrap modulo 256, larger seeds count straight up
    logic [31:0] exp_q[$];
    function automatic void build_exp(input logic [31:0] sv, input int n, input logic inj);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] v;
            v = (sv < 32'd256) ? (sv + 32'(i)) % 32'd256 : sv + 32'(i);
            exp_q.push_back((inj && i == 1) ? ~v : v);
        end
    endfunction

    task automatic launch(input logic [31:0] sv, input logic [23:0] n, input logic inj);
        @(posedge clk); #1;
        start_value = sv; word_count = n; inject_error = inj; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            ok = done;
        end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, words_sent, d_if.write_activate, d_if.write_strobe, d_if.write_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b ws=%0d act=%b stb=%b data=%h, want all 0",
                     busy, done, words_sent, d_if.write_activate, d_if.write_strobe, d_if.write_data);
        end
        @(posedge clk); #1 rst = 1;
    endtask

    task automatic test_full;
        int b, f, dn, nf;
        logic ok;
        b = got_q.size(); f = fills_q.size(); dn = done_cnt;
        launch(32'd0, 24'd512, 1'b0);
        wait_done(1500, ok);
        build_exp(32'd0, 512, 1'b0);
        vectors++; if (!ok) begin miscompares++; $display("FAIL full_done: done not seen"); end
        vectors++;
        if (got_q.size() - b != 512) begin miscompares++; $display("FAIL full_count: got %0d want 512", got_q.size() - b); end
        for (int i = 0; i < 512 && b + i < got_q.size(); i++) begin
            vectors++;
            if (got_q[b + i] !== exp_q[i]) begin
                miscompares++; $display("FAIL full_data[%0d]: got %h want %h", i, got_q[b + i], exp_q[i]);
            end
        end
        nf = fills_q.size() - f;
        vectors++;
        if (nf != 2 || fills_q[f] != 256 || fills_q[f + 1] != 256) begin
            miscompares++; $display("FAIL full_fills: got %0d fills (%0d,%0d) want 2 of 256", nf, fills_q[f], fills_q[f + 1]);
        end
        vectors++;
        if (bufs_q[f] !== 2'b01 || bufs_q[f + 1] !== 2'b10) begin
            miscompares++; $display("FAIL full_bufs: got %b,%b want 01,10", bufs_q[f], bufs_q[f + 1]);
        end
        vectors++; if (words_sent !== 24'd512) begin miscompares++; $display("FAIL full_ws: got %0d want 512", words_sent); end
        vectors++; if (done_cnt - dn != 1) begin miscompares++; $display("FAIL full_donecnt: got %0d want 1", done_cnt - dn); end
    endtask

    task automatic test_wrap;
        int b, f;
        logic ok;
        b = got_q.size(); f = fills_q.size();
        launch(32'd250, 24'd10, 1'b0);
        wait_done(200, ok);
        build_exp(32'd250, 10, 1'b0);
        vectors++;
        if (!ok || got_q.size() - b != 10) begin miscompares++; $display("FAIL wrap_count: done=%b got %0d want 10", ok, got_q.size() - b); end
        for (int i = 0; i < 10 && b + i < got_q.size(); i++) begin
            vectors++;
            if (got_q[b + i] !== exp_q[i]) begin
                miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got_q[b + i], exp_q[i]);
            end
        end
        vectors++;
        if (fills_q.size() - f != 1 || fills_q[f] != 10) begin
            miscompares++; $display("FAIL wrap_fill: got %0d fills first=%0d want 1 of 10", fills_q.size() - f, fills_q[f]);
        end
    endtask

    task automatic test_inject;
        int b, errs;
        logic ok;
        logic [31:0] want[4];
        want = '{32'd5, 32'hFFFFFFF9, 32'd7, 32'd8};
        b = got_q.size(); errs = 0;
        launch(32'd5, 24'd4, 1'b1);
        wait_done(200, ok);
        build_exp(32'd5, 4, 1'b0);
        vectors++;
        if (!ok || got_q.size() - b != 4) begin miscompares++; $display("FAIL inj_count: done=%b got %0d want 4", ok, got_q.size() - b); end
        for (int i = 0; i < 4 && b + i < got_q.size(); i++) begin
            errs += int'(got_q[b + i] !== exp_q[i]);
            vectors++;
            if (got_q[b + i] !== want[i]) begin
                miscompares++; $display("FAIL inj_data[%0d]: got %h want %h", i, got_q[b + i], want[i]);
            end
        end
        vectors++; if (errs != 1) begin miscompares++; $display("FAIL inj_checker: got %0d errors want 1", errs); end
    endtask

    task automatic test_stall;
        int k;
        logic ok, seen;
        mask = 2'b00;
        launch(32'd17, 24'd20, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (d_if.write_strobe !== 1'b0 || busy !== 1'b1) begin
                miscompares++; $display("FAIL stall_cycle%0d: strobe=%b busy=%b want 0,1", i, d_if.write_strobe, busy);
            end
        end
        @(posedge clk); #1 mask = 2'b10;
        seen = 0;
        for (k = 1; k <= 4 && !seen; k++) begin
            @(negedge clk);
            seen = d_if.write_strobe;
        end
        vectors++;
        if (!seen || k - 2 > 2) begin miscompares++; $display("FAIL stall_latency: seen=%b edges=%0d want <=2", seen, k - 2); end
        vectors++;
        if (d_if.write_activate !== 2'b10) begin miscompares++; $display("FAIL stall_buf: got %b want 10", d_if.write_activate); end
        wait_done(200, ok);
        vectors++; if (words_sent !== 24'd20) begin miscompares++; $display("FAIL stall_ws: got %0d want 20", words_sent); end
        mask = 2'b11;
    endtask

    task automatic test_abort;
        int cnt, b;
        logic ok;
        logic [31:0] sv;
        cnt = 0;
        launch(32'd0, 24'd300, 1'b0);
        for (int k = 0; k < 600 && cnt < 100; k++) begin
            @(negedge clk);
            cnt += int'(d_if.write_strobe);
        end
        vectors++; if (cnt != 100) begin miscompares++; $display("FAIL abort_reach: got %0d strobes want 100", cnt); end
        @(posedge clk); #1 abort = 1;
        @(negedge clk);
        vectors++; if (d_if.write_strobe !== 1'b0) begin miscompares++; $display("FAIL abort_strobe: got 1 want 0"); end
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        vectors++;
        if (d_if.write_activate !== 2'b00 || done !== 1'b1 || words_sent !== 24'd100) begin
            miscompares++; $display("FAIL abort_state: act=%b done=%b ws=%0d want 00,1,100", d_if.write_activate, done, words_sent);
        end
        sv = $urandom_range(0, 255);
        b = got_q.size();
        launch(sv, 24'd1, 1'b0);
        wait_done(100, ok);
        vectors++;
        if (got_q.size() - b != 1 || got_q[b] !== sv || words_sent !== 24'd1) begin
            miscompares++; $display("FAIL abort_next: n=%0d data=%h ws=%0d want 1,%h,1", got_q.size() - b, got_q[b], words_sent, sv);
        end
    endtask

    task automatic test_gap;
        int t[$];
        logic [31:0] d[$];
        logic [31:0] sv;
        sv = $urandom_range(0, 200);
        @(posedge clk); #1 start_value = sv; word_count = 24'd4; g_start = 1;
        @(posedge clk); #1 g_start = 0;
        for (int k = 0; k < 60 && !g_done; k++) begin
            @(negedge clk);
            if (g_if.write_strobe) begin t.push_back(cyc); d.push_back(g_if.write_data); end
        end
        vectors++; if (t.size() != 4) begin miscompares++; $display("FAIL gap_count: got %0d want 4", t.size()); end
        for (int i = 1; i < 4 && i < t.size(); i++) begin
            vectors++;
            if (t[i] - t[i - 1] != 4 || d[i] !== sv + 32'(i)) begin
                miscompares++; $display("FAIL gap_step%0d: spacing %0d data %h want 4,%h", i, t[i] - t[i - 1], d[i], sv + 32'(i));
            end
        end
        @(negedge clk);
        vectors++; if (g_ws !== 24'd4) begin miscompares++; $display("FAIL gap_ws: got %0d want 4", g_ws); end
    endtask

    task automatic test_reset_mid;
        int cnt, hits;
        logic ok;
        cnt = 0; hits = 0;
        launch(32'd0, 24'd300, 1'b0);
        for (int k = 0; k < 300 && cnt < 50; k++) begin
            @(negedge clk);
            cnt += int'(d_if.write_strobe);
        end
        @(posedge clk); #2 start = 1;
        #1 rst = 0;
        #1;
        vectors++;
        if ({busy, done, words_sent, d_if.write_activate, d_if.write_strobe, d_if.write_data} !== '0) begin
            miscompares++;
            $display("FAIL midrst_outputs: busy=%b done=%b ws=%0d act=%b stb=%b data=%h, want all 0",
                     busy, done, words_sent, d_if.write_activate, d_if.write_strobe, d_if.write_data);
        end
        @(negedge clk); rst = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            hits += int'(busy || d_if.write_strobe || d_if.write_activate != 0);
        end
        vectors++; if (hits != 0) begin miscompares++; $display("FAIL midrst_relaunch: %0d active cycles want 0", hits); end
        vectors++; if (words_sent !== 24'd0) begin miscompares++; $display("FAIL midrst_ws: got %0d want 0", words_sent); end
        start = 0;
        launch(32'd7, 24'd3, 1'b0);
        wait_done(100, ok);
        vectors++; if (!ok || words_sent !== 24'd3) begin miscompares++; $display("FAIL midrst_after: done=%b ws=%0d want 1,3", ok, words_sent); end
    endtask

    task automatic test_random;
        int b, f, dn, n, nf, k;
        logic ok, inj;
        logic [31:0] sv;
        for (int r = 0; r < 8; r++) begin
            sv = ($urandom_range(0, 3) == 0) ? $urandom_range(32'h7fffffff, 256) : $urandom_range(0, 255);
            n = (r == 0) ? 0 : int'($urandom_range(1, 700));
            inj = 1'($urandom_range(0, 1));
            b = got_q.size(); f = fills_q.size(); dn = done_cnt;
            launch(sv, 24'(n), inj);
            wait_done(2 * n + 100, ok);
            build_exp(sv, n, inj);
            vectors++;
            if (!ok || got_q.size() - b != n) begin
                miscompares++; $display("FAIL rand%0d_count: done=%b got %0d want %0d", r, ok, got_q.size() - b, n);
            end
            for (int i = 0; i < n && b + i < got_q.size(); i++) begin
                vectors++;
                if (got_q[b + i] !== exp_q[i]) begin
                    miscompares++; $display("FAIL rand%0d_data[%0d]: got %h want %h", r, i, got_q[b + i], exp_q[i]);
                end
            end
            k = (n + 255) / 256;
            nf = fills_q.size() - f;
            vectors++; if (nf != k) begin miscompares++; $display("FAIL rand%0d_nfills: got %0d want %0d", r, nf, k); end
            for (int j = 0; j < nf && j < k; j++) begin
                vectors++;
                if (fills_q[f + j] != ((j < k - 1) ? 256 : n - 256 * (k - 1))) begin
                    miscompares++; $display("FAIL rand%0d_fill%0d: got %0d want %0d", r, j, fills_q[f + j], (j < k - 1) ? 256 : n - 256 * (k - 1));
                end
            end
            vectors++;
            if (words_sent !== 24'(n) || done_cnt - dn != 1) begin
                miscompares++; $display("FAIL rand%0d_end: ws=%0d dones=%0d want %0d,1", r, words_sent, done_cnt - dn, n);
            end
        end
        vectors++; if (rule_viol != 0) begin miscompares++; $display("FAIL strobe_rule: got %0d violations want 0", rule_viol); end
    endtask

    initial begin
        test_reset;
        test_full;
        test_wrap;
        test_inject;
        test_stall;
        test_abort;
        test_gap;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
